// File: rtl/mcac_pkg.sv
// Shared definitions for the config Wishbone arbiter: FSM encodings and timeout default.
package mcac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_E = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/cfg_arb_rr2.sv
// Two-way round-robin tie-break; remembers which master was served last.
module cfg_arb_rr2 (
   input  logic clk,
   input  logic reset,
   input  logic req_e,
   input  logic req_d,
   input  logic update,
   input  logic served_d,
   output logic pick_d
);

   logic last_d_q;

   // Resets to "decoder served last" so the encoder wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b1;
      end else if (update) begin
         last_d_q <= served_d;
      end
   end

   always_comb begin
      pick_d = 1'b0;
      if (req_d && !req_e) begin
         pick_d = 1'b1;
      end else if (req_d && req_e) begin
         pick_d = !last_d_q;
      end
   end

endmodule

// File: rtl/cfg_wb_arb.sv
// Arbitrates the encoder and decoder Wishbone masters onto a single config-slave port,
// with a per-transfer wait counter that aborts a stalled transfer with an error.
module cfg_wb_arb
   import mcac_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned DW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   i_wb_adr_e,
   input  logic [31:0]   i_wb_adr_d,
   input  logic [3:0]    i_wb_sel_e,
   input  logic [3:0]    i_wb_sel_d,
   input  logic          i_wb_we_e,
   input  logic          i_wb_we_d,
   input  logic [DW-1:0] i_wb_dat_e,
   input  logic [DW-1:0] i_wb_dat_d,
   input  logic          i_wb_cyc_e,
   input  logic          i_wb_stb_e,
   input  logic          i_wb_cyc_d,
   input  logic          i_wb_stb_d,
   output logic [DW-1:0] o_wb_dat_e,
   output logic [DW-1:0] o_wb_dat_d,
   output logic          o_wb_ack_e,
   output logic          o_wb_err_e,
   output logic          o_wb_ack_d,
   output logic          o_wb_err_d,
   output logic [31:0]   o_s_wb_adr,
   output logic [3:0]    o_s_wb_sel,
   output logic          o_s_wb_we,
   output logic [DW-1:0] o_s_wb_dat,
   output logic          o_s_wb_cyc,
   output logic          o_s_wb_stb,
   input  logic [DW-1:0] i_s_wb_dat,
   input  logic          i_s_wb_ack,
   input  logic          i_s_wb_err,
   output logic [1:0]    o_grant,
   output logic          o_timeout
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   arb_state_e state_q, state_d;
   logic [7:0] cnt_q;
   logic       req_e, req_d, pick_d;
   logic       cyc_sel, resp, tmo_hit, update;

   assign req_e   = i_wb_cyc_e & i_wb_stb_e;
   assign req_d   = i_wb_cyc_d & i_wb_stb_d;
   assign resp    = i_s_wb_ack | i_s_wb_err;
   assign cyc_sel = (state_q == GNT_E) ? i_wb_cyc_e :
                    (state_q == GNT_D) ? i_wb_cyc_d : 1'b0;
   // A master that has already dropped cyc is aborting, so it gets no timeout error.
   assign tmo_hit = cyc_sel & !resp & (cnt_q == TMO_LAST);
   assign update  = (state_q != IDLE) && (state_d == IDLE);

   cfg_arb_rr2 u_rr (
      .clk      (clk),
      .reset    (reset),
      .req_e    (req_e),
      .req_d    (req_d),
      .update   (update),
      .served_d (state_q == GNT_D),
      .pick_d   (pick_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_e || req_d) begin
               state_d = pick_d ? GNT_D : GNT_E;
            end
         end
         GNT_E, GNT_D: begin
            if (resp || !cyc_sel || tmo_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (state_q == IDLE)) begin
         cnt_q <= 8'd0;
      end else if (!resp) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   always_comb begin
      o_s_wb_adr = '0;
      o_s_wb_sel = '0;
      o_s_wb_we  = 1'b0;
      o_s_wb_dat = '0;
      o_s_wb_cyc = 1'b0;
      o_s_wb_stb = 1'b0;
      o_wb_dat_e = '0;
      o_wb_dat_d = '0;
      o_wb_ack_e = 1'b0;
      o_wb_err_e = 1'b0;
      o_wb_ack_d = 1'b0;
      o_wb_err_d = 1'b0;
      o_grant    = {state_q == GNT_D, state_q == GNT_E};
      // Responses are suppressed while reset is high so an in-flight transfer ends silently.
      o_timeout  = tmo_hit & !reset;
      unique case (state_q)
         GNT_E: begin
            o_s_wb_adr = i_wb_adr_e;
            o_s_wb_sel = i_wb_sel_e;
            o_s_wb_we  = i_wb_we_e;
            o_s_wb_dat = i_wb_dat_e;
            o_s_wb_cyc = i_wb_cyc_e;
            o_s_wb_stb = i_wb_stb_e;
            o_wb_dat_e = i_s_wb_dat;
            o_wb_ack_e = i_s_wb_ack & !reset;
            o_wb_err_e = (i_s_wb_err | tmo_hit) & !reset;
         end
         GNT_D: begin
            o_s_wb_adr = i_wb_adr_d;
            o_s_wb_sel = i_wb_sel_d;
            o_s_wb_we  = i_wb_we_d;
            o_s_wb_dat = i_wb_dat_d;
            o_s_wb_cyc = i_wb_cyc_d;
            o_s_wb_stb = i_wb_stb_d;
            o_wb_dat_d = i_s_wb_dat;
            o_wb_ack_d = i_s_wb_ack & !reset;
            o_wb_err_d = (i_s_wb_err | tmo_hit) & !reset;
         end
         default: ;
      endcase
   end

endmodule
